// File: rtl/ex_exc_collect.sv
// ex_exc_collect: dual-way exception collector sitting at the ID/EX boundary,
// feeding cp0. Latches per-way decode exceptions, PCs and delay-slot flags,
// then prioritises them per way against EX overflow and data-address faults.
// Both ways are reported independently; cp0 does the cross-way arbitration.
// Optional build macro: EXC_OV_EN. When defined, ex_ov raises code 0c.
// When undefined, ex_ov is ignored and overflow never traps.

// Per-way prioritiser. Purely combinational: registered ID state plus live
// EX state in, cp0 code/vaddr/in_delay out.
module ex_exc_way #(
  parameter int ADDR_W = 32,
  parameter int CODE_W = 5
) (
  input  logic              v,
  input  logic              fetch_adel,
  input  logic              ri,
  input  logic              sys,
  input  logic              eret,
  input  logic              ds,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ov,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [CODE_W-1:0] code,
  output logic [ADDR_W-1:0] ade_vaddr,
  output logic [ADDR_W-1:0] adel_vaddr,
  output logic              in_delay
);
  localparam logic [CODE_W-1:0] C_ADEL = CODE_W'('h04);
  localparam logic [CODE_W-1:0] C_ADES = CODE_W'('h05);
  localparam logic [CODE_W-1:0] C_SYS  = CODE_W'('h08);
  localparam logic [CODE_W-1:0] C_RI   = CODE_W'('h0a);
  localparam logic [CODE_W-1:0] C_OV   = CODE_W'('h0c);
  localparam logic [CODE_W-1:0] C_NONE = CODE_W'('h10);
  localparam logic [CODE_W-1:0] C_ERET = CODE_W'('h11);

  logic misalign;
  logic ov_hit;

  // Alignment check on the EX address; byte never faults, size 11 is unused
  // by the decoder and is treated as non-faulting.
  always_comb begin
    misalign = 1'b0;
    case (mem_size)
      2'b01:   misalign = mem_addr[0];
      2'b10:   misalign = |mem_addr[1:0];
      default: misalign = 1'b0;
    endcase
  end

`ifdef EXC_OV_EN
  assign ov_hit = ov;
`else
  // Overflow is architecturally ignored in this build; the sink keeps the
  // port connected without affecting logic.
  logic unused_ov;
  assign unused_ov = ov;
  assign ov_hit    = 1'b0;
`endif

  // Fixed priority: fetch ADEL > RI > SYS > ERET > OV > data ADEL/ADES.
  always_comb begin
    code       = C_NONE;
    ade_vaddr  = '0;
    adel_vaddr = '0;
    in_delay   = 1'b0;
    if (v) begin
      in_delay = ds;
      if (fetch_adel) begin
        code       = C_ADEL;
        adel_vaddr = pc;
      end else if (ri) begin
        code = C_RI;
      end else if (sys) begin
        code = C_SYS;
      end else if (eret) begin
        code = C_ERET;
      end else if (ov_hit) begin
        code = C_OV;
      end else if (mem_re && misalign) begin
        code      = C_ADEL;
        ade_vaddr = mem_addr;
      end else if (mem_we && misalign) begin
        code      = C_ADES;
        ade_vaddr = mem_addr;
      end
    end
  end
endmodule

module ex_exc_collect #(
  parameter int ADDR_W = 32,
  parameter int CODE_W = 5
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                stall,
  input  logic                exc_flush_all,
  input  logic [1:0]          id_valid,
  input  logic [2*ADDR_W-1:0] id_pc,
  input  logic [1:0]          id_branch,
  input  logic [1:0]          id_ri,
  input  logic [1:0]          id_sys,
  input  logic [1:0]          id_eret,
  input  logic [1:0]          ex_mem_re,
  input  logic [1:0]          ex_mem_we,
  input  logic [3:0]          ex_mem_size,
  input  logic [2*ADDR_W-1:0] ex_mem_addr,
  input  logic [1:0]          ex_ov,
  output logic [2*CODE_W-1:0] ex_cp0_exc_code_i,
  output logic [2*ADDR_W-1:0] ex_cp0_exc_pc_i,
  output logic [2*ADDR_W-1:0] ex_cp0_ade_vaddr,
  output logic [2*ADDR_W-1:0] ex_cp0_adel_vaddr,
  output logic [1:0]          ex_cp0_in_delay_i
);
  localparam int NUM_WAYS = 2;

  typedef struct packed {
    logic fetch_adel;
    logic ri;
    logic sys;
    logic eret;
  } dec_t;

  logic [NUM_WAYS-1:0][ADDR_W-1:0] id_pc_w, pc_q, addr_w, ade_w, adel_w;
  logic [NUM_WAYS-1:0][1:0]        size_w;
  logic [NUM_WAYS-1:0][CODE_W-1:0] code_w;
  logic [NUM_WAYS-1:0]             v_q, ds_q, dly_w;
  dec_t [NUM_WAYS-1:0]             dec_d, dec_q;
  logic                            pending_ds;

  assign id_pc_w = id_pc;
  assign addr_w  = ex_mem_addr;
  assign size_w  = ex_mem_size;

  // Decode flags captured per way; fetch ADEL is a misaligned fetch PC.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      dec_d[w].fetch_adel = |id_pc_w[w][1:0];
      dec_d[w].ri         = id_ri[w];
      dec_d[w].sys        = id_sys[w];
      dec_d[w].eret       = id_eret[w];
    end
  end

  // ID/EX register. Flush beats stall; way1's delay slot comes from way0 of
  // the same packet, way0's from way1 of the previous valid packet.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      v_q        <= '0;
      pc_q       <= '0;
      dec_q      <= '0;
      ds_q       <= '0;
      pending_ds <= 1'b0;
    end else if (exc_flush_all) begin
      v_q        <= '0;
      ds_q       <= '0;
      pending_ds <= 1'b0;
    end else if (!stall) begin
      v_q     <= id_valid;
      pc_q    <= id_pc_w;
      dec_q   <= dec_d;
      ds_q[1] <= id_valid[0] && id_branch[0];
      ds_q[0] <= pending_ds;
      if (|id_valid)
        pending_ds <= id_valid[1] && id_branch[1];
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    ex_exc_way #(.ADDR_W(ADDR_W), .CODE_W(CODE_W)) u_way (
      .v          (v_q[w]),
      .fetch_adel (dec_q[w].fetch_adel),
      .ri         (dec_q[w].ri),
      .sys        (dec_q[w].sys),
      .eret       (dec_q[w].eret),
      .ds         (ds_q[w]),
      .pc         (pc_q[w]),
      .ov         (ex_ov[w]),
      .mem_re     (ex_mem_re[w]),
      .mem_we     (ex_mem_we[w]),
      .mem_size   (size_w[w]),
      .mem_addr   (addr_w[w]),
      .code       (code_w[w]),
      .ade_vaddr  (ade_w[w]),
      .adel_vaddr (adel_w[w]),
      .in_delay   (dly_w[w])
    );
  end

  assign ex_cp0_exc_code_i = code_w;
  assign ex_cp0_exc_pc_i   = pc_q;
  assign ex_cp0_ade_vaddr  = ade_w;
  assign ex_cp0_adel_vaddr = adel_w;
  assign ex_cp0_in_delay_i = dly_w;
endmodule
